// File: rtl/syn_fifo.sv
// Single-clock FIFO with registered read port, occupancy/threshold flags
// and sticky overflow/underflow error flags.
module syn_fifo #(
    parameter int data_width = 8,
    parameter int depth      = 8,
    parameter int af_level   = depth - 1,
    parameter int ae_level   = 1
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       push,
    input  logic [data_width-1:0]      data_in,
    input  logic                       pop,
    output logic [data_width-1:0]      data_out,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(depth):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);
    localparam logic [CW-1:0] AF_CNT   = CW'(af_level);
    localparam logic [CW-1:0] AE_CNT   = CW'(ae_level);

    logic [data_width-1:0] mem [depth];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // Flags decode registered count only, so no input reaches them combinationally.
    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Storage is intentionally not reset; a clear only resets the pointers.
    always_ff @(posedge clk) begin
        if (!clr && push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            // The read uses the pre-edge head, so a simultaneous push never bypasses.
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_syn_fifo.sv
// Directed and randomized bench for syn_fifo against a queue-based reference model.
module tb_syn_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          clr;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_vld;
    logic          m_ovf;
    logic          m_unf;

    syn_fifo #(.data_width(DW), .depth(DEPTH)) dut (
        .clk          (clk),
        .clr          (clr),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic c, input logic pu, input logic po, input logic [DW-1:0] d);
        bit was_full;
        bit was_empty;
        if (c) begin
            q.delete();
            m_dout = '0;
            m_vld  = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (pu && was_full)  m_ovf = 1'b1;
            if (po && was_empty) m_unf = 1'b1;
            m_vld = po && !was_empty;
            if (po && !was_empty) m_dout = q.pop_front();
            if (pu && !was_full)  q.push_back(d);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},     32'(count),        32'(q.size()));
        chk({tag, ".rd_valid"},  32'(rd_valid),     32'(m_vld));
        chk({tag, ".data_out"},  32'(data_out),     32'(m_dout));
        chk({tag, ".full"},      32'(full),         32'(q.size() == DEPTH));
        chk({tag, ".empty"},     32'(empty),        32'(q.size() == 0));
        chk({tag, ".afull"},     32'(almost_full),  32'(q.size() >= DEPTH - 1));
        chk({tag, ".aempty"},    32'(almost_empty), 32'(q.size() <= 1));
        chk({tag, ".overflow"},  32'(overflow),     32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow),    32'(m_unf));
    endtask

    task automatic step(input string tag, input logic c, input logic pu, input logic po,
                        input logic [DW-1:0] d);
        clr     = c;
        push    = pu;
        pop     = po;
        data_in = d;
        @(posedge clk);
        #1;
        model(c, pu, po, d);
        check_all(tag);
    endtask

    initial begin
        clr = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
        m_dout = '0; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

        // Reset state
        step("reset", 1'b1, 1'b0, 1'b0, 8'h00);
        chk("reset.empty_k", 32'(empty), 32'd1);
        chk("reset.aempty_k", 32'(almost_empty), 32'd1);

        // Fill and drain
        for (int i = 0; i < 8; i++) step("fill", 1'b0, 1'b1, 1'b0, 8'(8'h11 + i));
        chk("fill.full_k", 32'(full), 32'd1);
        chk("fill.count_k", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            step("drain", 1'b0, 1'b0, 1'b1, 8'h00);
            chk("drain.data_k", 32'(data_out), 32'(8'h11 + i));
            chk("drain.vld_k", 32'(rd_valid), 32'd1);
        end
        chk("drain.empty_k", 32'(empty), 32'd1);

        // Overflow at full, then overflow with simultaneous pop
        for (int i = 0; i < 8; i++) step("refill", 1'b0, 1'b1, 1'b0, 8'(8'h11 + i));
        step("ovf_push", 1'b0, 1'b1, 1'b0, 8'hAA);
        chk("ovf.count_k", 32'(count), 32'd8);
        chk("ovf.flag_k", 32'(overflow), 32'd1);
        step("ovf_pop", 1'b0, 1'b0, 1'b1, 8'h00);
        chk("ovf.head_k", 32'(data_out), 32'h11);
        step("ovf_refill", 1'b0, 1'b1, 1'b0, 8'h19);
        step("full_pushpop", 1'b0, 1'b1, 1'b1, 8'hBB);
        chk("full_pp.count_k", 32'(count), 32'd7);
        for (int i = 0; i < 7; i++) step("ovf_drain", 1'b0, 1'b0, 1'b1, 8'h00);
        chk("ovf.sticky_k", 32'(overflow), 32'd1);

        // Underflow from reset, and push+pop at empty
        step("clr2", 1'b1, 1'b0, 1'b0, 8'h00);
        step("unf_pop", 1'b0, 1'b0, 1'b1, 8'h00);
        chk("unf.vld_k", 32'(rd_valid), 32'd0);
        chk("unf.dout_k", 32'(data_out), 32'd0);
        chk("unf.flag_k", 32'(underflow), 32'd1);
        step("empty_pushpop", 1'b0, 1'b1, 1'b1, 8'h5C);
        chk("empty_pp.count_k", 32'(count), 32'd1);
        step("unf_read", 1'b0, 1'b0, 1'b1, 8'h00);
        chk("unf_read.data_k", 32'(data_out), 32'h5C);

        // Simultaneous push/pop mid-range
        step("clr3", 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 3; i++) step("sim_fill", 1'b0, 1'b1, 1'b0, 8'(i));
        step("sim_pp", 1'b0, 1'b1, 1'b1, 8'h04);
        chk("sim_pp.data_k", 32'(data_out), 32'h01);
        chk("sim_pp.count_k", 32'(count), 32'd3);
        for (int i = 2; i <= 4; i++) begin
            step("sim_drain", 1'b0, 1'b0, 1'b1, 8'h00);
            chk("sim_drain.data_k", 32'(data_out), 32'(i));
        end

        // Randomized interleaving with pointer wrap
        step("clr4", 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 80; i++) begin
            logic pu;
            logic po;
            pu = ($urandom_range(0, 99) < ((i % 40) < 20 ? 70 : 35));
            po = ($urandom_range(0, 99) < ((i % 40) < 20 ? 35 : 70));
            step("rand", 1'b0, pu, po, 8'($urandom));
        end

        // Clear mid-operation discards contents
        step("clr5", 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step("mid_fill", 1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
        step("mid_ovf", 1'b0, 1'b0, 1'b0, 8'h00);
        step("mid_clr", 1'b1, 1'b1, 1'b0, 8'h77);
        chk("mid_clr.count_k", 32'(count), 32'd0);
        chk("mid_clr.empty_k", 32'(empty), 32'd1);
        chk("mid_clr.ovf_k", 32'(overflow), 32'd0);
        chk("mid_clr.unf_k", 32'(underflow), 32'd0);
        step("mid_pop", 1'b0, 1'b0, 1'b1, 8'h00);
        chk("mid_pop.vld_k", 32'(rd_valid), 32'd0);
        chk("mid_pop.unf_k", 32'(underflow), 32'd1);

        clr = 1'b0; push = 1'b0; pop = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
